uart_tx_arbiter: RTL



---
 rtl/uart_tx_arb_pkg.sv | 37 +++
 rtl/uart_tx_arbiter_rr_picker.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
//   BYTE_W      : width of one transmitted byte
//   arb_state_t : arbiter FSM state encoding (also exported on dbg_state)
//   clog2       : ceiling log2 for parameter-derived widths
//   width_of    : bits needed to hold 0..max_value, never less than 1
package uart_tx_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_HOLD      = 3'd5
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int width_of(input int max_value);
    int w;
    w = clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req    : request vector, one bit per requester
//   ptr    : index with the highest priority this cycle
//   onehot : one-hot winner (all zero when no request)
//   idx    : binary index of the winner (0 when no request)
//   any    : at least one request present
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest offset back to the pointer so the candidate
  // closest to ptr (walking upward with wrap) is written last and wins.
  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one single-byte UART transmitter among N_REQ byte-stream requesters.
// Grants are round-robin, held for a whole packet (req_last) up to MAX_BURST
// bytes, and revoked if the owner stalls for HOLD_TIMEOUT clocks in HOLD.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_valid    : requester i has a byte
//   req_data     : byte of requester i at [8i+7:8i]
//   req_last     : byte is the last of its packet
//   req_ready    : combinational accept for requester i
//   grant        : one-hot transmitter owner, 0 when free
//   tx_start     : one-cycle start pulse to the transmitter
//   tx_data      : byte to the transmitter, stable until the next accept
//   tx_busy      : transmitter busy, rises the cycle after tx_start
//   err_timeout  : one-cycle pulse on missing busy or hold timeout
//   dbg_state    : current FSM state
//
// Handshake: a byte moves on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever raised in IDLE (for the
// round-robin winner) and HOLD (for the owner); it depends combinationally
// on req_valid and state, and req_data/req_last are sampled only on that edge.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    err_timeout,
  output arb_state_t              dbg_state
);

  localparam int IDX_W   = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam int BURST_W = width_of(MAX_BURST);
  localparam int GAP_W   = width_of(GAP_CYCLES);
  localparam int HOLD_W  = width_of(HOLD_TIMEOUT);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                wb_q, wb_d;        // second cycle in WAIT_BUSY
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                err_q, err_d;

  logic [N_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                decide;
  logic                rel_now;
  logic [IDX_W-1:0]    next_ptr;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Pointer moves just past the owner on every release, wrapping at N_REQ.
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    last_d    = last_q;
    burst_d   = burst_q;
    wb_d      = wb_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    err_d     = 1'b0;
    req_ready = '0;
    decide    = 1'b0;
    rel_now   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = pick_onehot;
        if (pick_any) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          data_d  = req_data[BYTE_W*int'(pick_idx) +: BYTE_W];
          last_d  = req_last[pick_idx];
          burst_d = BURST_W'(1);
          state_d = S_START;
        end
      end

      S_START: begin
        wb_d    = 1'b0;
        state_d = S_WAIT_BUSY;
      end

      // Busy should rise right after the start pulse; allow two cycles.
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wb_q) begin
          err_d   = 1'b1;
          rel_now = 1'b1;
        end else begin
          wb_d = 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            decide = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          decide = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      // Only the owner is served; everyone else waits for the release.
      S_HOLD: begin
        req_ready = grant_q;
        if (|(req_valid & grant_q)) begin
          data_d  = req_data[BYTE_W*int'(owner_q) +: BYTE_W];
          last_d  = req_last[owner_q];
          burst_d = burst_q + 1'b1;
          state_d = S_START;
        end else if (hold_q == HOLD_LAST) begin
          err_d   = 1'b1;
          rel_now = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // End of a byte: keep the grant unless the packet ended or the burst cap hit.
    if (decide) begin
      if (last_q || (burst_q == BURST_CAP)) begin
        rel_now = 1'b1;
      end else begin
        hold_d  = '0;
        state_d = S_HOLD;
      end
    end

    if (rel_now) begin
      grant_d = '0;
      ptr_d   = next_ptr;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      burst_q <= '0;
      wb_q    <= 1'b0;
      gap_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      wb_q    <= wb_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign grant       = grant_q;
  assign tx_start    = (state_q == S_START);
  assign tx_data     = data_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule
